// File: rtl/wb_ram_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter, fixed priority A over B, grant locked until slave ack.
// Latency: zero added; an idle bus passes the winning request to X combinationally in the same cycle.
// Backpressure: the losing master sees no ack and zero read data until the owner's transfer completes.
module wb_ram_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,

    input  logic             a_cyc,
    input  logic             a_we,
    input  logic [3:0]       a_sel,
    input  logic [WIDTH-1:0] a_adr,
    input  logic [31:0]      a_dat,
    output logic             a_ack,
    output logic [31:0]      a_rdt,

    input  logic             b_cyc,
    input  logic             b_we,
    input  logic [3:0]       b_sel,
    input  logic [WIDTH-1:0] b_adr,
    input  logic [31:0]      b_dat,
    output logic             b_ack,
    output logic [31:0]      b_rdt,

    output logic             x_cyc,
    output logic             x_we,
    output logic [3:0]       x_sel,
    output logic [WIDTH-1:0] x_adr,
    output logic [31:0]      x_dat,
    input  logic             x_ack,
    input  logic [31:0]      x_rdt
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } own_t;

    own_t owner;
    own_t owner_nxt;
    own_t grant;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            owner <= OWN_IDLE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // A locked owner keeps the bus; otherwise priority picks among live requests.
    always_comb begin
        grant = OWN_IDLE;
        if (owner != OWN_IDLE) begin
            grant = owner;
        end else if (a_cyc) begin
            grant = OWN_A;
        end else if (b_cyc) begin
            grant = OWN_B;
        end

        owner_nxt = grant;
        if (x_ack) begin
            owner_nxt = OWN_IDLE;
        end else if ((owner == OWN_A && !a_cyc) || (owner == OWN_B && !b_cyc)) begin
            owner_nxt = OWN_IDLE;
        end
    end

    always_comb begin
        x_cyc = 1'b0;
        x_we  = 1'b0;
        x_sel = '0;
        x_adr = '0;
        x_dat = '0;
        a_ack = 1'b0;
        b_ack = 1'b0;
        a_rdt = '0;
        b_rdt = '0;
        case (grant)
            OWN_A: begin
                x_cyc = a_cyc;
                x_we  = a_we;
                x_sel = a_sel;
                x_adr = a_adr;
                x_dat = a_dat;
                a_ack = x_ack;
                if (x_ack) begin
                    a_rdt = x_rdt;
                end
            end
            OWN_B: begin
                x_cyc = b_cyc;
                x_we  = b_we;
                x_sel = b_sel;
                x_adr = b_adr;
                x_dat = b_dat;
                b_ack = x_ack;
                if (x_ack) begin
                    b_rdt = x_rdt;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: two master drivers, a behavioural RAM slave with stalls,
// and a transaction-level memory reference updated in ack order.
module tb_wb_ram_arbiter;

    logic        wb_clk   = 1'b0;
    logic        wb_rst_n = 1'b0;

    logic        a_cyc, a_we, a_ack;
    logic [3:0]  a_sel;
    logic [31:0] a_adr, a_dat, a_rdt;
    logic        b_cyc, b_we, b_ack;
    logic [3:0]  b_sel;
    logic [31:0] b_adr, b_dat, b_rdt;
    logic        x_cyc, x_we, x_ack;
    logic [3:0]  x_sel;
    logic [31:0] x_adr, x_dat, x_rdt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] smem [16];
    logic [31:0] rmem [16];
    bit          stall    = 1'b0;
    bit          rnd_wait = 1'b0;
    bit          mem_clr  = 1'b1;
    bit          mon_on   = 1'b0;
    bit          prev_low = 1'b0;
    int          ack_log [$];
    logic [31:0] rda, rdb;

    always #5 wb_clk = ~wb_clk;

    wb_ram_arbiter #(.WIDTH(32)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .a_cyc(a_cyc), .a_we(a_we), .a_sel(a_sel), .a_adr(a_adr), .a_dat(a_dat),
        .a_ack(a_ack), .a_rdt(a_rdt),
        .b_cyc(b_cyc), .b_we(b_we), .b_sel(b_sel), .b_adr(b_adr), .b_dat(b_dat),
        .b_ack(b_ack), .b_rdt(b_rdt),
        .x_cyc(x_cyc), .x_we(x_we), .x_sel(x_sel), .x_adr(x_adr), .x_dat(x_dat),
        .x_ack(x_ack), .x_rdt(x_rdt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // RAM slave: acks at least one cycle after cyc, returns pre-write data, garbage rdt when not acking.
    always @(posedge wb_clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) smem[i] <= 32'h0;
            x_ack <= 1'b0;
            x_rdt <= 32'h0;
        end else if (!wb_rst_n) begin
            x_ack <= 1'b0;
            x_rdt <= $urandom;
        end else if (x_cyc && !x_ack && !stall && (!rnd_wait || $urandom_range(0, 2) != 0)) begin
            x_ack <= 1'b1;
            x_rdt <= smem[x_adr[5:2]];
            if (x_we) smem[x_adr[5:2]] <= merge(smem[x_adr[5:2]], x_dat, x_sel);
        end else begin
            x_ack <= 1'b0;
            x_rdt <= $urandom;
        end
    end

    always @(negedge wb_clk) begin
        if (mon_on) begin
            chk("ack_exclusive", 32'(a_ack & b_ack), 32'h0);
            if (!a_ack) chk("a_rdt_not_acked", a_rdt, 32'h0);
            if (!b_ack) chk("b_rdt_not_acked", b_rdt, 32'h0);
            if (a_ack) begin
                chk("x_ctl_for_a", 32'({x_cyc, x_we, x_sel}), 32'({1'b1, a_we, a_sel}));
                chk("x_adr_for_a", x_adr, a_adr);
                chk("x_dat_for_a", x_dat, a_dat);
            end
            if (b_ack) begin
                chk("x_ctl_for_b", 32'({x_cyc, x_we, x_sel}), 32'({1'b1, b_we, b_sel}));
                chk("x_adr_for_b", x_adr, b_adr);
                chk("x_dat_for_b", x_dat, b_dat);
            end
            if (!a_cyc && !b_cyc && prev_low) begin
                chk("x_idle_ctl", 32'({x_cyc, x_we, x_sel}), 32'h0);
                chk("x_idle_adr", x_adr, 32'h0);
                chk("x_idle_dat", x_dat, 32'h0);
            end
        end
        prev_low = !a_cyc && !b_cyc;
    end

    task automatic idle(input bit m);
        if (!m) begin
            a_cyc = 1'b0; a_we = 1'($urandom); a_sel = 4'($urandom);
            a_adr = $urandom; a_dat = $urandom;
        end else begin
            b_cyc = 1'b0; b_we = 1'($urandom); b_sel = 4'($urandom);
            b_adr = $urandom; b_dat = $urandom;
        end
    endtask

    task automatic align();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) align();
    endtask

    // Issues one transfer, scoreboards it when acked, then drops cyc on the edge that sampled ack.
    task automatic xfer(input bit m, input bit we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        rd  = 32'h0;
        if (!m) begin
            a_cyc = 1'b1; a_we = we; a_sel = sel; a_adr = adr; a_dat = dat;
        end else begin
            b_cyc = 1'b1; b_we = we; b_sel = sel; b_adr = adr; b_dat = dat;
        end
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge wb_clk);
            if (m ? b_ack : a_ack) begin
                got = 1'b1;
                rd  = m ? b_rdt : a_rdt;
                if (!we) chk(m ? "b_read_data" : "a_read_data", rd, rmem[adr[5:2]]);
                else     rmem[adr[5:2]] = merge(rmem[adr[5:2]], dat, sel);
                ack_log.push_back(int'(m));
            end
        end
        chk(m ? "b_ack_timeout" : "a_ack_timeout", 32'(got), 32'h1);
        align();
        idle(m);
    endtask

    initial begin
        idle(1'b0);
        idle(1'b1);
        for (int i = 0; i < 16; i++) rmem[i] = 32'h0;
        cyc_wait(3);
        chk("rst_x_ctl", 32'({x_cyc, x_we, x_sel}), 32'h0);
        chk("rst_x_adr", x_adr, 32'h0);
        chk("rst_acks", 32'({a_ack, b_ack}), 32'h0);
        chk("rst_rdt", a_rdt | b_rdt, 32'h0);
        mem_clr  = 1'b0;
        wb_rst_n = 1'b1;
        mon_on   = 1'b1;
        align();

        // Single write by A: X bus carries it immediately and returns to zero after release.
        fork
            xfer(1'b0, 1'b1, 4'hF, 32'h20, 32'h12343456, rda);
            begin
                @(negedge wb_clk);
                chk("w_a_x_ctl", 32'({x_cyc, x_we, x_sel}), 32'h3F);
                chk("w_a_x_adr", x_adr, 32'h20);
                chk("w_a_x_dat", x_dat, 32'h12343456);
            end
        join
        @(negedge wb_clk);
        chk("release_x_ctl", 32'({x_cyc, x_we, x_sel}), 32'h0);
        chk("release_x_adr", x_adr, 32'h0);
        chk("release_x_dat", x_dat, 32'h0);
        align();

        xfer(1'b1, 1'b1, 4'hF, 32'h10, 32'hcafecafe, rdb);
        xfer(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, rda);
        chk("a_read_20", rda, 32'h12343456);
        xfer(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, rdb);
        chk("b_read_10", rdb, 32'hcafecafe);
        xfer(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, rda);
        chk("a_read_10", rda, 32'hcafecafe);
        xfer(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, rdb);
        chk("b_read_20", rdb, 32'h12343456);

        // Simultaneous writes to one address: A first, B's value survives.
        ack_log.delete();
        fork
            xfer(1'b0, 1'b1, 4'hF, 32'h08, 32'h12341234, rda);
            xfer(1'b1, 1'b1, 4'hF, 32'h08, 32'habcdabcd, rdb);
        join
        chk("sim_ack_count", 32'(ack_log.size()), 32'h2);
        if (ack_log.size() == 2) chk("sim_first_is_a", 32'(ack_log[0]), 32'h0);
        xfer(1'b0, 1'b0, 4'hF, 32'h08, 32'h0, rda);
        chk("sim_readback", rda, 32'habcdabcd);

        xfer(1'b0, 1'b1, 4'hF, 32'h00, 32'h00000000, rda);
        xfer(1'b1, 1'b1, 4'hF, 32'h04, 32'h11111111, rdb);
        for (int off = -2; off <= 2; off++) begin
            fork
                begin
                    cyc_wait(off < 0 ? -off : 0);
                    xfer(1'b0, 1'b0, 4'hF, 32'h00, 32'h0, rda);
                end
                begin
                    cyc_wait(off > 0 ? off : 0);
                    xfer(1'b1, 1'b0, 4'hF, 32'h04, 32'h0, rdb);
                end
            join
            chk("ovl_a_data", rda, 32'h00000000);
            chk("ovl_b_data", rdb, 32'h11111111);
        end

        // Same-cycle read by A and write by B: A sees the old word.
        xfer(1'b0, 1'b1, 4'hF, 32'h14, 32'hfaceface, rda);
        fork
            xfer(1'b0, 1'b0, 4'hF, 32'h14, 32'h0, rda);
            xfer(1'b1, 1'b1, 4'hF, 32'h14, 32'h12345678, rdb);
        join
        chk("rw_old_data", rda, 32'hfaceface);
        xfer(1'b0, 1'b0, 4'hF, 32'h14, 32'h0, rda);
        chk("rw_new_data", rda, 32'h12345678);

        // Abort: A drops cyc without ack; B must still be served.
        stall = 1'b1;
        a_cyc = 1'b1; a_we = 1'b1; a_sel = 4'hF; a_adr = 32'h3c; a_dat = 32'hdeadbeef;
        cyc_wait(2);
        a_cyc = 1'b0;
        stall = 1'b0;
        fork
            xfer(1'b1, 1'b0, 4'hF, 32'h3c, 32'h0, rdb);
            begin
                @(negedge wb_clk);
                chk("abort_x_cyc", 32'(x_cyc), 32'h0);
                chk("abort_b_ack", 32'(b_ack), 32'h0);
            end
        join
        chk("abort_no_write", rdb, 32'h0);

        // Reset while B owns the bus with A waiting.
        ack_log.delete();
        stall = 1'b1;
        fork
            xfer(1'b1, 1'b1, 4'hF, 32'h18, 32'h5a5a5a5a, rdb);
            begin
                cyc_wait(2);
                xfer(1'b0, 1'b0, 4'hF, 32'h18, 32'h0, rda);
            end
            begin
                repeat (4) @(posedge wb_clk);
                @(negedge wb_clk);
                chk("lock_b_x_adr", x_adr, 32'h18);
                chk("lock_b_x_we", 32'(x_we), 32'h1);
                align();
                wb_rst_n = 1'b0;
                #1;
                chk("rst_regrant_a_we", 32'({x_cyc, x_we}), 32'h2);
                chk("rst_regrant_a_adr", x_adr, 32'h18);
                align();
                wb_rst_n = 1'b1;
                stall    = 1'b0;
            end
        join
        chk("rst_ack_count", 32'(ack_log.size()), 32'h2);
        if (ack_log.size() == 2) chk("rst_first_is_a", 32'(ack_log[0]), 32'h0);
        chk("rst_a_old_data", rda, 32'h0);

        rnd_wait = 1'b1;
        fork
            for (int i = 0; i < 30; i++) begin
                cyc_wait($urandom_range(0, 3));
                xfer(1'b0, 1'($urandom), 4'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom, rda);
            end
            for (int j = 0; j < 30; j++) begin
                cyc_wait($urandom_range(0, 3));
                xfer(1'b1, 1'($urandom), 4'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom, rdb);
            end
        join
        cyc_wait(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
